seg7_event_counter: RTL and testbench
=====================================

Name: seg7_event_counter

Overview:
- Parametrised successor of the single-digit button press counter.
- Debounces increment, decrement and clear buttons, and keeps a DIGITS-wide up/down counter in BCD or hex.
- Drives a time-multiplexed, active-low, multi-digit seven-segment display.
- Sits directly under the board-level wrapper, with ports named after the board pins.

Parameters:
- DIGITS, 8, number of display digits and counter digits (1..8)
- BCD_MODE, 1, 1 = decimal digits 0-9, 0 = hex digits 0-F
- DEBOUNCE_CYCLES, 1000000, stable-level cycles required before a button change is accepted (>=2)
- REFRESH_CYCLES, 100000, clock cycles each digit is lit before advancing (>=2)

Ports:
- CLK100MHZ  in  1  100 MHz system clock
- CPU_RESETN  in  1  asynchronous active-low reset
- BTNC  in  1  increment button, raw, asynchronous
- BTNL  in  1  decrement button, raw, asynchronous
- BTNR  in  1  clear button, raw, asynchronous
- AN  out  DIGITS  digit enables, active-low, one-hot-zero
- CA, CB, CC, CD, CE, CF, CG  out  1 each  segments a..g, active-low
- DP  out  1  decimal point, active-low; always 1 (off)
- COUNT  out  4*DIGITS  current counter value, nibble per digit, digit 0 in LSBs

Behaviour:
- Reset (CPU_RESETN=0, takes effect asynchronously):
  - synchronisers, debouncers and counter go to 0; scan index goes to 0
  - AN = all ones, CA..CG = 1, DP = 1, COUNT = 0
  - State releases on the first CLK100MHZ edge after CPU_RESETN rises.
- Input path, per button:
  - 2-FF synchroniser feeding a debouncer.
  - The debouncer's stable output changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A rising edge of the stable output produces a one-cycle press pulse.
  - Latency from raw edge to pulse is DEBOUNCE_CYCLES+3 cycles.
- Counter update priority, evaluated each cycle:
  - clear: COUNT = 0
  - else inc and dec pulses in the same cycle: no change
  - else inc: +1
  - else dec: -1
- Arithmetic:
  - Digit-wise ripple with carry/borrow; the result is visible on COUNT the cycle after the pulse.
  - BCD: digit 9 + 1 gives 0 with carry.
  - Hex: F + 1 gives 0 with carry.
- Wrap-around:
  - Max value (all 9s or all Fs) + 1 gives 0.
  - 0 - 1 gives max value.
  - No sticky overflow.
- Scan:
  - Refresh counter counts 0..REFRESH_CYCLES-1; at terminal count the scan index advances, wrapping DIGITS-1 to 0.
  - First digit is lit at the first cycle after reset release: AN[0]=0.
  - AN[i]=0 only when scan index = i.
  - CA..CG show the active-low 7-seg pattern of COUNT nibble i, registered with the same latency as AN, so there is no ghosting.
- Hex glyphs A b C d E F; in BCD mode digits are never >9.
- A button held down counts once; release is debounced too, and the next press counts again.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit above the most significant non-zero digit is blanked: AN still scans, CA..CG = all 1.
  - Digit 0 always displays, so value 0 shows a single "0".
- Undefined: all DIGITS always display, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - typedef seg7_t, a 7-bit vector ordered {g,f,e,d,c,b,a}
  - SEG7_BLANK constant (7'h7F)
  - function seg7_encode(nibble) returning the active-low pattern for 0-F
  - localparam BCD_MAX_DIGIT = 4'd9
- Sub-module button_debounce, parameter DEBOUNCE_CYCLES, ports:
  - CLK100MHZ, CPU_RESETN
  - btn_raw in
  - btn_level out
  - btn_press out (one-cycle pulse)
- One instance per button.

Test Plan (bench: DIGITS=4, DEBOUNCE_CYCLES=4, REFRESH_CYCLES=8, BCD_MODE=1 unless noted):
- Reset: CPU_RESETN low mid-operation with COUNT=0x0042 -> COUNT=0, AN=4'hF, CA..CG=1 immediately; after release AN=4'b1110 within 2 cycles.
- Debounce: BTNC toggled every 2 cycles for 20 cycles, then held high 40 cycles -> exactly one increment, COUNT=0x0001. Held 3 cycles only -> no increment.
- Carry/wrap:
  - BCD: 10 presses from 0x0009 -> 0x0019.
  - BCD: 0x9999 + 1 -> 0x0000; then BTNL press -> 0x9999.
  - BCD_MODE=0: 0x00FF + 1 -> 0x0100.
- Simultaneous events:
  - BTNC and BTNL pulses in the same cycle -> COUNT unchanged.
  - BTNR with BTNC -> COUNT=0.
- Scan: COUNT=0x1234 -> AN cycles 1110, 1101, 1011, 0111, each for 8 cycles. Segments show 4 (7'b0011001), 3, 2, 1 in step, with no cycle of mismatch.
- LEADING_ZERO_BLANK_EN defined:
  - COUNT=0x0050 -> digits 3 and 2 blank; digit 1 shows 5; digit 0 shows 0.
  - COUNT=0 -> only digit 0 shows 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Seven-segment glyph types and encoder shared by the event counter (combinational only).
// No latency, no flow control.
package seg7_pkg;

  // Segment vector ordered {g,f,e,d,c,b,a}; a 0 lights the segment.
  typedef logic [6:0] seg7_t;

  localparam seg7_t      SEG7_BLANK    = 7'h7F;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  function automatic seg7_t seg7_encode(input logic [3:0] nibble);
    seg7_t seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces one raw button; press pulse lands DEBOUNCE_CYCLES+3 cycles after the raw edge.
// No backpressure: the pulse is one cycle wide and is consumed unconditionally.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
      level_d   <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      // Any cycle where the input agrees with the stable level restarts the window.
      if (sync2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_level <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_d   <= btn_level;
      btn_press <= btn_level & ~level_d;
    end
  end

endmodule

// File: rtl/seg7_event_counter.sv
// Debounced up/down BCD/hex counter on a scanned active-low 7-seg display; COUNT updates the cycle after a press pulse.
// No backpressure. Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module seg7_event_counter
  import seg7_pkg::*;
#(
  parameter int DIGITS          = 8,
  parameter bit BCD_MODE        = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 100000
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic                BTNC,
  input  logic                BTNL,
  input  logic                BTNR,
  output logic [DIGITS-1:0]   AN,
  output logic                CA,
  output logic                CB,
  output logic                CC,
  output logic                CD,
  output logic                CE,
  output logic                CF,
  output logic                CG,
  output logic                DP,
  output logic [4*DIGITS-1:0] COUNT
);

  localparam int               CNT_W     = 4 * DIGITS;
  localparam int               IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int               REF_W     = $clog2(REFRESH_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [3:0]       DIGIT_MAX = BCD_MODE ? BCD_MAX_DIGIT : 4'hF;

  logic inc_press, dec_press, clr_press;
  logic unused_level_inc, unused_level_dec, unused_level_clr;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .btn_raw(BTNC),
    .btn_level(unused_level_inc), .btn_press(inc_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .btn_raw(BTNL),
    .btn_level(unused_level_dec), .btn_press(dec_press)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .btn_raw(BTNR),
    .btn_level(unused_level_clr), .btn_press(clr_press)
  );

  logic [CNT_W-1:0] count, cnt_inc, cnt_dec;
  logic             carry, borrow;
  logic [3:0]       dig;

  // Digit-wise ripple; a digit at its limit wraps and passes the carry/borrow on.
  always_comb begin
    cnt_inc = count;
    cnt_dec = count;
    carry   = 1'b1;
    borrow  = 1'b1;
    dig     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count[4*i +: 4];
      if (carry) begin
        if (dig == DIGIT_MAX) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = dig + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (dig == 4'd0) begin
          cnt_dec[4*i +: 4] = DIGIT_MAX;
        end else begin
          cnt_dec[4*i +: 4] = dig - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      count <= '0;
    end else if (clr_press) begin
      count <= '0;
    end else if (inc_press && !dec_press) begin
      count <= cnt_inc;
    end else if (dec_press && !inc_press) begin
      count <= cnt_dec;
    end
  end

  logic [DIGITS-1:0] lead_zero;
  logic              above;

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lead_zero = '0;
    above     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      above        = above & (count[4*i +: 4] == 4'd0);
      lead_zero[i] = above;
    end
  end
`else
  assign lead_zero = '0;
  assign above     = 1'b0;
`endif

  logic [IDX_W-1:0] scan_idx;
  logic [REF_W-1:0] ref_cnt;
  logic [3:0]       cur_nib;
  logic             cur_blank;

  always_comb begin
    cur_nib   = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == scan_idx) begin
        cur_nib   = count[4*i +: 4];
        cur_blank = lead_zero[i];
      end
    end
  end

  logic [DIGITS-1:0] an_q;
  seg7_t             seg_q;

  // AN and segments are registered from the same scan index, so they switch together.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      ref_cnt  <= '0;
      scan_idx <= '0;
      an_q     <= '1;
      seg_q    <= SEG7_BLANK;
    end else begin
      if (ref_cnt == REF_LAST) begin
        ref_cnt  <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      an_q  <= ~(DIGITS'(1) << scan_idx);
      seg_q <= cur_blank ? SEG7_BLANK : seg7_encode(cur_nib);
    end
  end

  assign AN                           = an_q;
  assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
  assign DP                           = 1'b1;
  assign COUNT                        = count;

endmodule

// File: tb/tb_seg7_event_counter.sv
// Directed bench for seg7_event_counter: a BCD instance and a hex instance share buttons and reset.
// Expected values are hand-computed constants; build with LEADING_ZERO_BLANK_EN to exercise blanking.
module tb_seg7_event_counter;

  localparam int DB = 4;
  localparam int RF = 8;

  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN = 1'b1;
  logic        BTNC = 1'b0, BTNL = 1'b0, BTNR = 1'b0;
  logic [3:0]  AN;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;
  logic [15:0] COUNT;
  logic [15:0] count_h;
  logic [3:0]  unused_an_h;
  logic [7:0]  unused_seg_h;

  int vectors = 0;
  int miscompares = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  seg7_event_counter #(.DIGITS(4), .BCD_MODE(1'b1), .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF)) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .BTNC(BTNC), .BTNL(BTNL), .BTNR(BTNR),
    .AN(AN), .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP), .COUNT(COUNT)
  );

  seg7_event_counter #(.DIGITS(4), .BCD_MODE(1'b0), .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF)) dut_hex (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .BTNC(BTNC), .BTNL(BTNL), .BTNR(BTNR),
    .AN(unused_an_h), .CA(unused_seg_h[0]), .CB(unused_seg_h[1]), .CC(unused_seg_h[2]),
    .CD(unused_seg_h[3]), .CE(unused_seg_h[4]), .CF(unused_seg_h[5]), .CG(unused_seg_h[6]),
    .DP(unused_seg_h[7]), .COUNT(count_h)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  wire [6:0] seg = {CG, CF, CE, CD, CC, CB, CA};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic press(input logic c, input logic l, input logic r);
    BTNC = c; BTNL = l; BTNR = r;
    tick(DB + 5);
    BTNC = 1'b0; BTNL = 1'b0; BTNR = 1'b0;
    tick(DB + 5);
  endtask

  task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    int n;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    n = 0;
    while (AN !== 4'b0111 && n < 40) begin tick(1); n++; end
    while (AN === 4'b0111 && n < 40) begin tick(1); n++; end
    chk({tag, "_align"}, 16'(n < 40), 16'd1);
    for (int k = 0; k < 32; k++) begin
      exp_an = ~(4'b0001 << (k / 8));
      chk({tag, "_an"}, 16'(AN), 16'(exp_an));
      chk({tag, "_seg"}, 16'(seg), 16'(exp_seg[k / 8]));
      tick(1);
    end
  endtask

  initial begin
    // Power-on reset, then release.
    #2 CPU_RESETN = 1'b0;
    #1;
    chk("por_an", 16'(AN), 16'hF);
    chk("por_seg", 16'(seg), 16'h7F);
    chk("por_dp", 16'(DP), 16'h1);
    chk("por_count", COUNT, 16'h0);
    tick(2);
    CPU_RESETN = 1'b1;
    tick(1);
    chk("rel_an", 16'(AN), 16'hE);
    chk("rel_seg", 16'(seg), 16'h40);

    // Bouncing input never settles long enough; a long hold counts once.
    for (int i = 0; i < 10; i++) begin
      BTNC = ~BTNC;
      tick(2);
    end
    chk("bounce", COUNT, 16'h0);
    BTNC = 1'b1; tick(40);
    chk("held", COUNT, 16'h1);
    BTNC = 1'b0; tick(12);
    chk("release", COUNT, 16'h1);
    BTNC = 1'b1; tick(3);
    BTNC = 1'b0; tick(12);
    chk("short", COUNT, 16'h1);

    // Bring the count to 42, then reset mid-operation.
    for (int i = 0; i < 41; i++) press(1'b1, 1'b0, 1'b0);
    chk("to42", COUNT, 16'h0042);
    #3 CPU_RESETN = 1'b0;
    #1;
    chk("mrst_count", COUNT, 16'h0);
    chk("mrst_an", 16'(AN), 16'hF);
    chk("mrst_seg", 16'(seg), 16'h7F);
    chk("mrst_dp", 16'(DP), 16'h1);
    #2 CPU_RESETN = 1'b1;
    tick(1);
    chk("mrel_an", 16'(AN), 16'hE);
    chk("mrel_count", COUNT, 16'h0);

    // BCD carry.
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 1'b0);
    chk("bcd9", COUNT, 16'h0009);
    for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 1'b0);
    chk("bcd19", COUNT, 16'h0019);

    // Simultaneous events.
    press(1'b1, 1'b1, 1'b0);
    chk("inc_dec", COUNT, 16'h0019);
    press(1'b1, 1'b0, 1'b1);
    chk("clr_inc", COUNT, 16'h0);
    chk("clr_inc_hex", count_h, 16'h0);

    // Wrap-around in both directions.
    press(1'b0, 1'b1, 1'b0);
    chk("dec_wrap", COUNT, 16'h9999);
    chk("dec_wrap_hex", count_h, 16'hFFFF);
    press(1'b1, 1'b0, 1'b0);
    chk("inc_wrap", COUNT, 16'h0000);
    chk("inc_wrap_hex", count_h, 16'h0000);
    press(1'b0, 1'b1, 1'b0);
    chk("dec_wrap2", COUNT, 16'h9999);
    chk("dec_wrap2_hex", count_h, 16'hFFFF);

    // Long run: hex 00FF -> 0100 on the way to BCD 1234.
    press(1'b0, 1'b0, 1'b1);
    chk("clr", COUNT, 16'h0);
    for (int i = 1; i <= 1234; i++) begin
      press(1'b1, 1'b0, 1'b0);
      if (i == 255) begin
        chk("bcd255", COUNT, 16'h0255);
        chk("hex_ff", count_h, 16'h00FF);
      end
      if (i == 256) chk("hex_100", count_h, 16'h0100);
    end
    chk("bcd1234", COUNT, 16'h1234);
    chk("hex_4d2", count_h, 16'h04D2);
    scan_check("scan1234", 7'h19, 7'h30, 7'h24, 7'h79);

    // Leading-zero display behaviour.
    press(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) press(1'b1, 1'b0, 1'b0);
    chk("bcd50", COUNT, 16'h0050);
    scan_check("scan50", 7'h40, 7'h12, LZ, LZ);
    press(1'b0, 1'b0, 1'b1);
    chk("zero", COUNT, 16'h0);
    scan_check("scan0", 7'h40, LZ, LZ, LZ);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
